// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// This is a buffered serial transmitter. The CPU bus writes words into a
// circular FIFO. A framing FSM pops the FIFO head and sends it on uart_tx as
// one frame:
//
//   start (0) | DATA_BITS data, LSB first | optional parity | STOP_BITS stop (1)
//
// Every bit lasts CLKS_PER_BIT cycles. When a frame ends and the FIFO still
// holds data, the next start bit follows straight away, so there is no idle
// gap between frames.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of 2, >= 2)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   CLK         system clock
//   RST         asynchronous reset, active high
//   wr_en       single-cycle write strobe
//   wr_data     write word; only bits [DATA_BITS-1:0] are kept
//   ovf_clr     clears the sticky overflow flag
//   uart_tx     serial line, idle high (registered)
//   fifo_level  number of FIFO entries (registered)
//   fifo_full   fifo_level == FIFO_DEPTH (registered)
//   fifo_empty  fifo_level == 0 (registered)
//   busy        framing FSM is not idle (registered)
//   overflow    sticky; set when a write is dropped (registered)
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | line high, waiting for a FIFO entry
//   S_START  | start bit (0) for one bit time
//   S_DATA   | shifting data bits out, LSB first
//   S_PARITY | parity bit for one bit time (only when PARITY != 0)
//   S_STOP   | stop bit(s) (1); pops the next entry back-to-back if present
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          ovf_clr,
    output logic                          uart_tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          busy,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = 3;

    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state, state_next;

    // FIFO storage and control
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [LW-1:0]        level_next;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 pop;
    logic                 wr_accept;

    // framing datapath
    logic [BW-1:0]        baud_cnt;
    logic                 baud_tc;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] sh_r;
    logic                 par_r;
    logic                 tx_next;
    logic                 busy_next;

    // Upper wr_data bits are architecturally ignored when DATA_BITS < 8.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data;

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    assign fifo_head = mem[rd_ptr];

    // A write at full is still taken when the FSM pops in the same cycle.
    assign wr_accept = wr_en && (!fifo_full || pop);

    always_comb begin
        level_next = fifo_level;
        case ({wr_accept, pop})
            2'b10:   level_next = fifo_level + LW'(1);
            2'b01:   level_next = fifo_level - LW'(1);
            default: level_next = fifo_level;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level <= level_next;
            fifo_empty <= (level_next == '0);
            fifo_full  <= (level_next == LW'(FIFO_DEPTH));
            // A drop wins over a clear in the same cycle.
            if (wr_en && !wr_accept) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; entries only become visible through the level.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data[DATA_BITS-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Framing FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign baud_tc = (baud_cnt == '0);

    // -------------------------------------------------------------------------
    // Framing FSM: next state and pop request
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tc && bit_cnt == '0) begin
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tc && bit_cnt == '0) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Framing FSM: output values for the next cycle
    // -------------------------------------------------------------------------
    always_comb begin
        tx_next   = uart_tx;
        busy_next = (state_next != S_IDLE);
        case (state)
            S_IDLE: begin
                tx_next = !pop;
            end
            S_START: begin
                if (baud_tc) begin
                    tx_next = sh_r[0];
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    if (bit_cnt != '0) begin
                        // sh_r shifts on this edge, so bit 1 becomes the next LSB
                        tx_next = sh_r[1];
                    end else begin
                        tx_next = (PARITY != 0) ? par_r : 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    tx_next = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tc && bit_cnt == '0) begin
                    tx_next = !pop;
                end
            end
            default: begin
                tx_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            uart_tx <= 1'b1;
            busy    <= 1'b0;
        end else begin
            uart_tx <= tx_next;
            busy    <= busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Baud timer, bit counter, shift register, parity
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh_r     <= '0;
            par_r    <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                if (pop) begin
                    baud_cnt <= BAUD_LOAD;
                end
            end else if (baud_tc) begin
                baud_cnt <= BAUD_LOAD;
            end else begin
                baud_cnt <= baud_cnt - BW'(1);
            end

            // bit_cnt counts remaining data bits, then remaining stop bits
            case (state)
                S_START: begin
                    if (baud_tc) begin
                        bit_cnt <= DATA_LAST;
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        bit_cnt <= (bit_cnt != '0) ? bit_cnt - CW'(1) : STOP_LAST;
                    end
                end
                S_PARITY: begin
                    if (baud_tc) begin
                        bit_cnt <= STOP_LAST;
                    end
                end
                S_STOP: begin
                    if (baud_tc && bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                default: begin
                    bit_cnt <= bit_cnt;
                end
            endcase

            if (pop) begin
                sh_r  <= fifo_head;
                par_r <= (PARITY == 1) ? ~(^fifo_head) : (^fifo_head);
            end else if (state == S_DATA && baud_tc && bit_cnt != '0) begin
                sh_r <= sh_r >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// This bench drives three transmitter instances:
//   dut_a : 8N1,  CLKS_PER_BIT=4, FIFO_DEPTH=4
//   dut_e : 7E2,  CLKS_PER_BIT=4, FIFO_DEPTH=8
//   dut_o : 7O2,  CLKS_PER_BIT=4, FIFO_DEPTH=8
//
// A UART receiver model on dut_a pops the expected byte from a queue for each
// received frame. The parity instances are compared cycle by cycle against a
// frame model.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic       wr_en_a, ovf_clr_a, uart_tx_a, fifo_full_a, fifo_empty_a, busy_a, overflow_a;
    logic [7:0] wr_data_a;
    logic [2:0] fifo_level_a;

    logic       wr_en_e, ovf_clr_e, uart_tx_e, fifo_full_e, fifo_empty_e, busy_e, overflow_e;
    logic [7:0] wr_data_e;
    logic [3:0] fifo_level_e;

    logic       wr_en_o, ovf_clr_o, uart_tx_o, fifo_full_o, fifo_empty_o, busy_o, overflow_o;
    logic [7:0] wr_data_o;
    logic [3:0] fifo_level_o;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST(RST), .wr_en(wr_en_a), .wr_data(wr_data_a), .ovf_clr(ovf_clr_a),
        .uart_tx(uart_tx_a), .fifo_level(fifo_level_a), .fifo_full(fifo_full_a),
        .fifo_empty(fifo_empty_a), .busy(busy_a), .overflow(overflow_a)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_e (
        .CLK(CLK), .RST(RST), .wr_en(wr_en_e), .wr_data(wr_data_e), .ovf_clr(ovf_clr_e),
        .uart_tx(uart_tx_e), .fifo_level(fifo_level_e), .fifo_full(fifo_full_e),
        .fifo_empty(fifo_empty_e), .busy(busy_e), .overflow(overflow_e)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_o (
        .CLK(CLK), .RST(RST), .wr_en(wr_en_o), .wr_data(wr_data_o), .ovf_clr(ovf_clr_o),
        .uart_tx(uart_tx_o), .fifo_level(fifo_level_o), .fifo_full(fifo_full_o),
        .fifo_empty(fifo_empty_o), .busy(busy_o), .overflow(overflow_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected line level k cycles (1-based) after the start-bit edge, CLKS_PER_BIT=4.
    function automatic logic frame_bit(input logic [7:0] d, input int nb, input int np,
                                       input logic p, input int k);
        int b;
        b = (k - 1) / 4;
        if (b == 0) return 1'b0;
        if (b <= nb) return d[b-1];
        if (np != 0 && b == nb + 1) return p;
        return 1'b1;
    endfunction

    // ---------------------------------------------------------------- scoreboard
    logic [7:0] exp_q[$];
    bit         mon_ign    = 1'b0;
    int         rx_cnt     = 0;
    int         cyc        = 0;
    int         prev_start = 0;
    int         last_start = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Receiver model for dut_a: 8N1 at 4 clocks/bit, samples in the bit middle.
    initial begin : rx_model
        logic [7:0] d;
        logic       st0;
        logic       sp;
        forever begin
            @(negedge CLK);
            if (uart_tx_a === 1'b0) begin
                prev_start = last_start;
                last_start = cyc;
                repeat (2) @(negedge CLK);
                st0 = uart_tx_a;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge CLK);
                    d[i] = uart_tx_a;
                end
                repeat (4) @(negedge CLK);
                sp = uart_tx_a;
                @(negedge CLK);
                if (!mon_ign) begin
                    chk("rx_start_bit", {31'd0, st0}, 32'd0);
                    chk("rx_stop_bit", {31'd0, sp}, 32'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected: got %02h expected no frame", d);
                    end else begin
                        chk("rx_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
                    end
                    rx_cnt++;
                end
            end
        end
    end

    // Caller is parked on a negedge; the write is sampled by the next posedge.
    task automatic wr_a(input logic [7:0] d);
        wr_en_a   = 1'b1;
        wr_data_a = d;
        @(negedge CLK);
        wr_en_a   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_a !== 1'b0 || fifo_empty_a !== 1'b1) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(name, {31'd0, (n < budget)}, 32'd1);
    endtask

    typedef struct {
        logic [7:0] wdata;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] wdata;
        logic [6:0] exp_d;
        logic       exp_pe;
        logic       exp_po;
    } pvec_t;

    vec_t       vt[6];
    pvec_t      pv[5];
    logic [7:0] ov[6];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0;

        vt[0] = '{8'h00, 0, 8'h00};
        vt[1] = '{8'hFF, 0, 8'hFF};
        vt[2] = '{8'h0F, 3, 8'h0F};
        vt[3] = '{8'hF0, 0, 8'hF0};
        vt[4] = '{8'h81, 60, 8'h81};
        vt[5] = '{8'h7E, 0, 8'h7E};

        pv[0] = '{8'h07, 7'h07, 1'b1, 1'b0};
        pv[1] = '{8'h80, 7'h00, 1'b0, 1'b1};
        pv[2] = '{8'h55, 7'h55, 1'b0, 1'b1};
        pv[3] = '{8'hFF, 7'h7F, 1'b1, 1'b0};
        pv[4] = '{8'h2A, 7'h2A, 1'b1, 1'b0};

        ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33;
        ov[3] = 8'h44; ov[4] = 8'h55; ov[5] = 8'h66;

        RST = 1'b1;
        wr_en_a = 1'b0; wr_data_a = 8'h00; ovf_clr_a = 1'b0;
        wr_en_e = 1'b0; wr_data_e = 8'h00; ovf_clr_e = 1'b0;
        wr_en_o = 1'b0; wr_data_o = 8'h00; ovf_clr_o = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // reset state
        chk("rst_tx", {31'd0, uart_tx_a}, 32'd1);
        chk("rst_level", {29'd0, fifo_level_a}, 32'd0);
        chk("rst_empty", {31'd0, fifo_empty_a}, 32'd1);
        chk("rst_full", {31'd0, fifo_full_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_a}, 32'd0);
        chk("rst_tx_e", {31'd0, uart_tx_e}, 32'd1);
        chk("rst_tx_o", {31'd0, uart_tx_o}, 32'd1);

        // 0x55 8N1, cycle-exact frame and latency
        exp_q.push_back(8'h55);
        wr_a(8'h55);
        chk("lat_level_n", {29'd0, fifo_level_a}, 32'd1);
        chk("lat_tx_n", {31'd0, uart_tx_a}, 32'd1);
        for (int k = 1; k <= 41; k++) begin
            @(negedge CLK);
            if (k == 1) chk("lat_level_n1", {29'd0, fifo_level_a}, 32'd0);
            if (k <= 40) begin
                chk($sformatf("tx55_k%0d", k), {31'd0, uart_tx_a},
                    {31'd0, frame_bit(8'h55, 8, 0, 1'b0, k)});
                chk($sformatf("busy55_k%0d", k), {31'd0, busy_a}, 32'd1);
            end else begin
                chk("busy55_fall", {31'd0, busy_a}, 32'd0);
                chk("tx55_idle", {31'd0, uart_tx_a}, 32'd1);
            end
        end
        wait_drain("drain_55", 200);

        // table-driven stream through the scoreboard
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vt[i].exp);
            wr_a(vt[i].wdata);
            repeat (vt[i].gap) @(negedge CLK);
        end
        wait_drain("drain_stream", 600);

        // back-to-back frames with no idle gap
        c0 = rx_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        wr_a(8'hA5);
        wr_a(8'h3C);
        for (int n = 0; n < 200 && rx_cnt < c0 + 2; n++) @(negedge CLK);
        chk("b2b_frames", rx_cnt - c0, 32'd2);
        chk("b2b_start_gap", last_start - prev_start, 32'd40);
        wait_drain("drain_b2b", 200);

        // fill to full, drop, sticky overflow, clear
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                chk("ovf_level4", {29'd0, fifo_level_a}, 32'd4);
                chk("ovf_full", {31'd0, fifo_full_a}, 32'd1);
                chk("ovf_not_yet", {31'd0, overflow_a}, 32'd0);
            end
            if (i < 5) exp_q.push_back(ov[i]);
            wr_en_a   = 1'b1;
            wr_data_a = ov[i];
            @(negedge CLK);
        end
        chk("ovf_set", {31'd0, overflow_a}, 32'd1);
        chk("ovf_level_kept", {29'd0, fifo_level_a}, 32'd4);
        chk("ovf_full_kept", {31'd0, fifo_full_a}, 32'd1);
        chk("ovf_empty", {31'd0, fifo_empty_a}, 32'd0);
        wr_data_a = 8'hEE;
        ovf_clr_a = 1'b1;
        @(negedge CLK);
        chk("ovf_drop_beats_clr", {31'd0, overflow_a}, 32'd1);
        wr_en_a = 1'b0;
        @(negedge CLK);
        ovf_clr_a = 1'b0;
        chk("ovf_cleared", {31'd0, overflow_a}, 32'd0);

        // write at full in the same cycle as the end-of-frame pop
        repeat (33) @(negedge CLK);
        chk("wp_pre_level", {29'd0, fifo_level_a}, 32'd4);
        chk("wp_pre_busy", {31'd0, busy_a}, 32'd1);
        exp_q.push_back(8'hC3);
        wr_a(8'hC3);
        chk("wp_level", {29'd0, fifo_level_a}, 32'd4);
        chk("wp_full", {31'd0, fifo_full_a}, 32'd1);
        chk("wp_no_ovf", {31'd0, overflow_a}, 32'd0);
        wait_drain("drain_full", 600);

        // asynchronous reset in the middle of DATA
        mon_ign = 1'b1;
        wr_a(8'h69);
        wr_a(8'h96);
        repeat (10) @(negedge CLK);
        chk("pre_rst_tx", {31'd0, uart_tx_a}, 32'd0);
        chk("pre_rst_level", {29'd0, fifo_level_a}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_tx", {31'd0, uart_tx_a}, 32'd1);
        chk("arst_level", {29'd0, fifo_level_a}, 32'd0);
        chk("arst_busy", {31'd0, busy_a}, 32'd0);
        chk("arst_empty", {31'd0, fifo_empty_a}, 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (50) @(negedge CLK);
        mon_ign = 1'b0;
        chk("post_rst_tx", {31'd0, uart_tx_a}, 32'd1);
        chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
        exp_q.push_back(8'hC6);
        wr_a(8'hC6);
        wait_drain("drain_post_rst", 200);

        // 7E2 / 7O2 frames, cycle-exact, upper wr_data bit ignored
        for (int i = 0; i < 5; i++) begin
            wr_en_e = 1'b1; wr_data_e = pv[i].wdata;
            wr_en_o = 1'b1; wr_data_o = pv[i].wdata;
            @(negedge CLK);
            wr_en_e = 1'b0;
            wr_en_o = 1'b0;
            for (int k = 1; k <= 45; k++) begin
                @(negedge CLK);
                if (k <= 44) begin
                    chk($sformatf("tx_e_v%0d_k%0d", i, k), {31'd0, uart_tx_e},
                        {31'd0, frame_bit({1'b0, pv[i].exp_d}, 7, 1, pv[i].exp_pe, k)});
                    chk($sformatf("tx_o_v%0d_k%0d", i, k), {31'd0, uart_tx_o},
                        {31'd0, frame_bit({1'b0, pv[i].exp_d}, 7, 1, pv[i].exp_po, k)});
                    if (k == 44) begin
                        chk($sformatf("busy_e_v%0d_end", i), {31'd0, busy_e}, 32'd1);
                        chk($sformatf("busy_o_v%0d_end", i), {31'd0, busy_o}, 32'd1);
                    end
                end else begin
                    chk($sformatf("busy_e_v%0d_fall", i), {31'd0, busy_e}, 32'd0);
                    chk($sformatf("busy_o_v%0d_fall", i), {31'd0, busy_o}, 32'd0);
                    chk($sformatf("tx_e_v%0d_idle", i), {31'd0, uart_tx_e}, 32'd1);
                end
            end
        end

        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
